// File: rtl/cache_memory.sv
// Direct-mapped L1 fetch data array: one-cycle registered line read with
// pass-through of tag/index/offset, plus an independent refill write port.
module cache_memory #(
  parameter int TAG_WIDTH    = 51,
  parameter int INDEX_WIDTH  = 8,
  parameter int OFFSET_WIDTH = 5,
  parameter int LINE_WIDTH   = 256
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    fetchEnable_i,
  input  logic [0:TAG_WIDTH-1]    tag_i,
  input  logic [0:INDEX_WIDTH-1]  index_i,
  input  logic [0:OFFSET_WIDTH-1] offset_i,
  input  logic                    updateEnable_i,
  input  logic [0:LINE_WIDTH-1]   newCacheline_i,
  input  logic [0:INDEX_WIDTH-1]  newIndex_i,
  output logic [0:TAG_WIDTH-1]    tag_o,
  output logic [0:INDEX_WIDTH-1]  index_o,
  output logic [0:OFFSET_WIDTH-1] offset_o,
  output logic [0:LINE_WIDTH-1]   cacheline_o,
  output logic                    enable_o
);

  localparam int DEPTH = 32'd1 << INDEX_WIDTH;

  logic [0:LINE_WIDTH-1]   lines_r [0:DEPTH-1];
  logic [0:TAG_WIDTH-1]    tag_r;
  logic [0:INDEX_WIDTH-1]  index_r;
  logic [0:OFFSET_WIDTH-1] offset_r;
  logic [0:LINE_WIDTH-1]   cacheline_r;
  logic                    enable_r;

  logic                    bypass_s;
  logic [0:LINE_WIDTH-1]   read_line_s;

  // Same-edge refill of the fetched set is forwarded so the fetch never sees stale data.
  always_comb begin
    bypass_s    = 1'b0;
    read_line_s = lines_r[index_i];
    if (updateEnable_i && (newIndex_i == index_i)) begin
      bypass_s    = 1'b1;
      read_line_s = newCacheline_i;
    end else begin
      bypass_s    = 1'b0;
      read_line_s = lines_r[index_i];
    end
  end

  // Refill write port; the array itself is never cleared, only frozen during reset.
  always_ff @(posedge clock_i) begin
    if (reset_i && updateEnable_i) begin
      lines_r[newIndex_i] <= newCacheline_i;
    end
  end

  // Fetch result registers; they hold their contents on idle cycles.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      tag_r       <= {TAG_WIDTH{1'b0}};
      index_r     <= {INDEX_WIDTH{1'b0}};
      offset_r    <= {OFFSET_WIDTH{1'b0}};
      cacheline_r <= {LINE_WIDTH{1'b0}};
      enable_r    <= 1'b0;
    end else if (fetchEnable_i) begin
      tag_r       <= tag_i;
      index_r     <= index_i;
      offset_r    <= offset_i;
      cacheline_r <= read_line_s;
      enable_r    <= 1'b1;
    end else begin
      enable_r    <= 1'b0;
    end
  end

  assign tag_o       = tag_r;
  assign index_o     = index_r;
  assign offset_o    = offset_r;
  assign cacheline_o = cacheline_r;
  assign enable_o    = enable_r;

endmodule

// File: tb/tb_cache_memory.sv
// Directed bench for cache_memory: reset, write/read, isolation, bypass,
// back-to-back fetches and mid-stream reset with array retention.
module tb_cache_memory;

  logic           clock_i;
  logic           reset_i;
  logic           fetchEnable_i;
  logic [0:50]    tag_i;
  logic [0:7]     index_i;
  logic [0:4]     offset_i;
  logic           updateEnable_i;
  logic [0:255]   newCacheline_i;
  logic [0:7]     newIndex_i;
  logic [0:50]    tag_o;
  logic [0:7]     index_o;
  logic [0:4]     offset_o;
  logic [0:255]   cacheline_o;
  logic           enable_o;

  int errors = 0;
  int checks = 0;

  localparam logic [0:255] LINE0 = 256'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA_99999999_88888888;
  localparam logic [0:255] LINE1 = 256'h88888888_99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD_EEEEEEEE_FFFFFFFF;
  localparam logic [0:255] LINE3 = 256'h01234567_89ABCDEF_FEDCBA98_76543210_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam logic [0:255] LINEA = 256'hA5A5A5A5_5A5A5A5A_12345678_9ABCDEF0_DEADBEEF_CAFEF00D_00000001_80000000;
  localparam logic [0:255] LINEB = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_12121212;
  localparam logic [0:255] JUNK  = 256'hBADBADBA_DBADBADB_ADBADBAD_BADBADBA_DBADBADB_ADBADBAD_BADBADBA_DBADBADB;

  cache_memory dut (
    .clock_i(clock_i), .reset_i(reset_i), .fetchEnable_i(fetchEnable_i),
    .tag_i(tag_i), .index_i(index_i), .offset_i(offset_i),
    .updateEnable_i(updateEnable_i), .newCacheline_i(newCacheline_i),
    .newIndex_i(newIndex_i), .tag_o(tag_o), .index_o(index_o),
    .offset_o(offset_o), .cacheline_o(cacheline_o), .enable_o(enable_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic drive(input logic fe, input logic [0:50] tg, input logic [0:7] ix,
                       input logic [0:4] of, input logic ue, input logic [0:7] nix,
                       input logic [0:255] ln);
    fetchEnable_i  = fe;
    tag_i          = tg;
    index_i        = ix;
    offset_i       = of;
    updateEnable_i = ue;
    newIndex_i     = nix;
    newCacheline_i = ln;
  endtask

  task automatic cyc();
    @(posedge clock_i);
    #1;
  endtask

  task automatic expect_out(input string name, input logic en, input logic [0:50] tg,
                            input logic [0:7] ix, input logic [0:4] of, input logic [0:255] ln);
    checks++;
    assert (enable_o === en) else begin
      errors++;
      $error("FAIL %s enable_o got=%b exp=%b", name, enable_o, en);
    end
    checks++;
    assert (tag_o === tg) else begin
      errors++;
      $error("FAIL %s tag_o got=%h exp=%h", name, tag_o, tg);
    end
    checks++;
    assert (index_o === ix) else begin
      errors++;
      $error("FAIL %s index_o got=%h exp=%h", name, index_o, ix);
    end
    checks++;
    assert (offset_o === of) else begin
      errors++;
      $error("FAIL %s offset_o got=%h exp=%h", name, offset_o, of);
    end
    checks++;
    assert (cacheline_o === ln) else begin
      errors++;
      $error("FAIL %s cacheline_o got=%h exp=%h", name, cacheline_o, ln);
    end
  endtask

  initial begin
    reset_i = 1'b1;
    drive(1'b1, 51'd999, 8'd2, 5'd3, 1'b1, 8'd2, JUNK);
    #2;
    reset_i = 1'b0;
    #1;
    expect_out("reset_async", 1'b0, 51'd0, 8'd0, 5'd0, 256'd0);
    cyc();
    cyc();
    expect_out("reset_held", 1'b0, 51'd0, 8'd0, 5'd0, 256'd0);

    reset_i = 1'b1;
    drive(1'b0, 51'd0, 8'd0, 5'd0, 1'b0, 8'd0, 256'd0);
    cyc();
    expect_out("post_reset_idle", 1'b0, 51'd0, 8'd0, 5'd0, 256'd0);

    drive(1'b0, 51'd0, 8'd0, 5'd0, 1'b1, 8'd0, LINE0);
    cyc();
    expect_out("write_no_enable", 1'b0, 51'd0, 8'd0, 5'd0, 256'd0);
    drive(1'b1, 51'd55, 8'd0, 5'd7, 1'b0, 8'd0, 256'd0);
    cyc();
    expect_out("read_idx0", 1'b1, 51'd55, 8'd0, 5'd7, LINE0);

    drive(1'b0, 51'd0, 8'd0, 5'd0, 1'b1, 8'd1, LINE1);
    cyc();
    drive(1'b1, 51'd123, 8'd1, 5'd4, 1'b0, 8'd0, 256'd0);
    cyc();
    expect_out("read_idx1", 1'b1, 51'd123, 8'd1, 5'd4, LINE1);
    drive(1'b0, 51'd77, 8'd9, 5'd9, 1'b0, 8'd0, 256'd0);
    cyc();
    expect_out("idle_hold", 1'b0, 51'd123, 8'd1, 5'd4, LINE1);

    drive(1'b1, 51'd7, 8'd0, 5'd0, 1'b0, 8'd0, 256'd0);
    cyc();
    expect_out("isolate_idx0", 1'b1, 51'd7, 8'd0, 5'd0, LINE0);
    drive(1'b0, 51'd0, 8'd0, 5'd0, 1'b1, 8'd3, LINE3);
    cyc();
    drive(1'b1, 51'd3, 8'd3, 5'd31, 1'b0, 8'd0, 256'd0);
    cyc();
    expect_out("read_idx3", 1'b1, 51'd3, 8'd3, 5'd31, LINE3);

    drive(1'b1, 51'h7FFFFFFFFFFFF, 8'd5, 5'd1, 1'b1, 8'd5, LINEA);
    cyc();
    expect_out("bypass_idx5", 1'b1, 51'h7FFFFFFFFFFFF, 8'd5, 5'd1, LINEA);
    drive(1'b1, 51'd5, 8'd5, 5'd2, 1'b0, 8'd0, 256'd0);
    cyc();
    expect_out("after_bypass_idx5", 1'b1, 51'd5, 8'd5, 5'd2, LINEA);
    drive(1'b1, 51'd33, 8'd3, 5'd0, 1'b1, 8'd255, LINEB);
    cyc();
    expect_out("split_fetch_idx3", 1'b1, 51'd33, 8'd3, 5'd0, LINE3);
    drive(1'b1, 51'd34, 8'd255, 5'd5, 1'b0, 8'd0, 256'd0);
    cyc();
    expect_out("split_write_idx255", 1'b1, 51'd34, 8'd255, 5'd5, LINEB);

    drive(1'b1, 51'd10, 8'd0, 5'd1, 1'b0, 8'd0, 256'd0);
    cyc();
    expect_out("b2b_0", 1'b1, 51'd10, 8'd0, 5'd1, LINE0);
    drive(1'b1, 51'd11, 8'd1, 5'd2, 1'b0, 8'd0, 256'd0);
    cyc();
    expect_out("b2b_1", 1'b1, 51'd11, 8'd1, 5'd2, LINE1);
    drive(1'b1, 51'd12, 8'd0, 5'd3, 1'b0, 8'd0, 256'd0);
    cyc();
    expect_out("b2b_2", 1'b1, 51'd12, 8'd0, 5'd3, LINE0);
    drive(1'b1, 51'd13, 8'd1, 5'd4, 1'b1, 8'd0, JUNK);
    #1;
    reset_i = 1'b0;
    #1;
    expect_out("mid_reset", 1'b0, 51'd0, 8'd0, 5'd0, 256'd0);
    cyc();
    expect_out("reset_ignores_ops", 1'b0, 51'd0, 8'd0, 5'd0, 256'd0);

    reset_i = 1'b1;
    drive(1'b1, 51'd20, 8'd0, 5'd6, 1'b0, 8'd0, 256'd0);
    cyc();
    expect_out("retain_idx0", 1'b1, 51'd20, 8'd0, 5'd6, LINE0);
    drive(1'b1, 51'd21, 8'd1, 5'd7, 1'b0, 8'd0, 256'd0);
    cyc();
    expect_out("retain_idx1", 1'b1, 51'd21, 8'd1, 5'd7, LINE1);
    drive(1'b0, 51'd0, 8'd0, 5'd0, 1'b0, 8'd0, 256'd0);
    cyc();
    expect_out("final_idle", 1'b0, 51'd21, 8'd1, 5'd7, LINE1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_memory.md
# cache_memory

Direct-mapped L1 cache data array for the PowerISA CPU front end: 256 lines of 256 bits (32-byte lines), indexed by an 8-bit set index from a 64-bit effective address split as tag[51] / index[8] / offset[5]. A fetch request reads the line at `index_i` and forwards it with the request's tag, index and offset to the next pipeline stage (tag compare and word select happen downstream). A separate update port writes refill lines into the array.

## Interface
Parameters:
- TAG_WIDTH, 51, address tag bits
- INDEX_WIDTH, 8, set index bits; array depth = 2^INDEX_WIDTH = 256
- OFFSET_WIDTH, 5, byte offset within line
- LINE_WIDTH, 256, cache line bits

Ports (all vectors big-endian `[0:W-1]`, bit 0 = MSB):
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-low reset
- fetchEnable_i  in  1  fetch request valid this cycle
- tag_i  in  51  request tag, passed through
- index_i  in  8  request set index (read address)
- offset_i  in  5  request byte offset, passed through
- updateEnable_i  in  1  write the refill line this cycle
- newCacheline_i  in  256  refill line data
- newIndex_i  in  8  refill set index (write address)
- tag_o  out  51  registered tag of the fetch
- index_o  out  8  registered index of the fetch
- offset_o  out  5  registered offset of the fetch
- cacheline_o  out  256  line read from array[index]
- enable_o  out  1  outputs carry a valid fetch result

## Operation
- Storage: 256 × 256-bit array, no valid bits, no tag store.
- Write: on a rising edge with updateEnable_i=1, array[newIndex_i] <= newCacheline_i. Writes do not affect enable_o.
- Fetch: on a rising edge with fetchEnable_i=1: tag_o<=tag_i, index_o<=index_i, offset_o<=offset_i, cacheline_o<=array[index_i], enable_o<=1.
- No fetch (fetchEnable_i=0): enable_o<=0; tag_o/index_o/offset_o/cacheline_o hold their previous values.
- Simultaneous fetch and update, same index (index_i==newIndex_i): write-through bypass — cacheline_o receives newCacheline_i, and the array is also written.
- Simultaneous fetch and update, different indices: both proceed independently in the same cycle.
- Reset (reset_i=0, asynchronous): enable_o=0, tag_o=0, index_o=0, offset_o=0, cacheline_o=0 immediately. Array contents are not cleared. Writes and fetches are ignored while reset is asserted.
- Reset asserted mid-stream discards any result on the outputs. First fetch after deassertion behaves normally.

## Timing
- Read latency is 1 cycle: a request sampled at edge N is on the outputs from just after edge N until edge N+1, with enable_o=1.
- Write latency is 1 cycle: a line written at edge N can be fetched from edge N+1 onward. Same-edge fetches of that index are served by the bypass.
- Fully pipelined: one fetch and one update accepted every cycle. No stall or backpressure.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset: drive reset_i=0 with arbitrary inputs → all outputs 0, enable_o=0. Release and clock once with fetchEnable_i=0 → enable_o stays 0.
- Write then read: update idx 0 with FFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA_99999999_88888888. Next cycle, fetch tag=55, idx=0, off=7 → after that edge: enable_o=1, tag_o=55, index_o=0, offset_o=7, cacheline_o=that line.
- Interleaved: update idx 1 with 88888888_99999999_…_FFFFFFFF, then fetch tag=123, idx=1, off=4 → cacheline_o=88888888_…_FFFFFFFF, tag_o=123, offset_o=4. Idle cycle → enable_o=0, data held.
- Isolation: after both writes, fetch idx 0 → line 0 value unchanged by the idx-1 write. Fetch idx 3 after writing idx 3 → idx-3 data.
- Bypass: same cycle, update idx 5 with line A and fetch idx 5 → cacheline_o=A. Next-cycle fetch of idx 5 → A.
- Back-to-back: fetches on 4 consecutive cycles to idx 0,1,0,1 → enable_o high for 4 cycles, each output matches its request one cycle later. Assert reset mid-sequence → outputs zero at once, array data intact afterward.
